// File: rtl/aes_sched_pkg.sv
// Shared constants and types for the AES decryption slot scheduler.
package aes_sched_pkg;

  localparam int unsigned AES_NUM_SLOTS    = 3;
  localparam logic [4:0]  AES_LAST_ROUND   = 5'd10;
  localparam int unsigned AES_PIPE_LATENCY = 30;
  localparam int unsigned AES_PERF_W       = 32;

  typedef logic [127:0] aes_block_t;

endpackage

// File: rtl/aes_out_fifo.sv
// Show-ahead synchronous plaintext FIFO, DEPTH x 128 bits; rd_data reads 0 while empty.
module aes_out_fifo
  import aes_sched_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  aes_block_t wr_data,
  input  logic       rd_en,
  output aes_block_t rd_data,
  output logic       full,
  output logic       empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  aes_block_t       mem [DEPTH];
  logic [PTR_W:0]   wr_ptr;
  logic [PTR_W:0]   rd_ptr;

  // Pointers carry one extra wrap bit to tell full from empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
      if (rd_en) rd_ptr <= rd_ptr + (PTR_W+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[PTR_W-1:0]] <= wr_data;
  end

  always_comb begin
    empty   = (wr_ptr == rd_ptr);
    full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
              (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    rd_data = empty ? '0 : mem[rd_ptr[PTR_W-1:0]];
  end

endmodule

// File: rtl/aes_dec_scheduler.sv
// Slot scheduler / flow control for the 3-stage recirculating AES decryption ring.
// Optional perf counters are built only when AES_SCHED_PERF_EN is defined.
module aes_dec_scheduler
  import aes_sched_pkg::*;
#(
  parameter int unsigned OUT_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  key_ready,
  input  logic                  fifo_empty,
  output logic                  read_fifo,
  output logic                  pipe_stall,
  input  logic                  pipe_done,
  input  aes_block_t            pipe_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output aes_block_t            out_data,
  output logic                  busy,
  output logic [AES_PERF_W-1:0] perf_blocks,
  output logic [AES_PERF_W-1:0] perf_stalls
);

  localparam int unsigned HEAD = AES_NUM_SLOTS - 1;

  logic [AES_NUM_SLOTS-1:0] occ;
  logic head_done;
  logic head_free;
  logic slot_in;
  logic ofifo_wr;
  logic ofifo_pop;
  logic ofifo_full;
  logic ofifo_empty;

  // Issue / stall decisions; pipe_done is only trusted when the head slot is live.
  always_comb begin
    head_done  = occ[HEAD] & pipe_done;
    head_free  = ~occ[HEAD] | head_done;
    ofifo_pop  = ~ofifo_empty & out_ready;
    pipe_stall = head_done & ofifo_full & ~ofifo_pop;
    read_fifo  = head_free & ~fifo_empty & key_ready & ~pipe_stall;
    ofifo_wr   = head_done & ~pipe_stall;
    // Slot 0 is occupied next by a fresh block or by the unfinished head recirculating.
    slot_in    = read_fifo | (occ[HEAD] & ~head_done);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occ <= '0;
    end else if (!pipe_stall) begin
      occ <= {occ[HEAD-1:0], slot_in};
    end
  end

  aes_out_fifo #(
    .DEPTH (OUT_DEPTH)
  ) u_out_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (ofifo_wr),
    .wr_data (pipe_data),
    .rd_en   (ofifo_pop),
    .rd_data (out_data),
    .full    (ofifo_full),
    .empty   (ofifo_empty)
  );

  always_comb begin
    out_valid = ~ofifo_empty;
    busy      = (|occ) | ~ofifo_empty;
  end

`ifdef AES_SCHED_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_blocks <= '0;
      perf_stalls <= '0;
    end else begin
      if (ofifo_wr)   perf_blocks <= perf_blocks + AES_PERF_W'(1);
      if (pipe_stall) perf_stalls <= perf_stalls + AES_PERF_W'(1);
    end
  end
`else
  assign perf_blocks = '0;
  assign perf_stalls = '0;
`endif

endmodule

// File: tb/tb_aes_dec_scheduler.sv
// Scoreboard bench for aes_dec_scheduler with a behavioural 3-stage recirculating datapath.
module tb_aes_dec_scheduler;
  import aes_sched_pkg::*;

  localparam int unsigned OUT_DEPTH  = 2;
  localparam aes_block_t  KEY_MASK   = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
  localparam logic [3:0]  LAST_VISIT = 4'd9;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        key_ready = 1'b0;
  logic        out_ready = 1'b0;
  logic        force_done = 1'b0;
  logic        fifo_empty;
  logic        read_fifo;
  logic        pipe_stall;
  logic        pipe_done;
  aes_block_t  pipe_data;
  logic        out_valid;
  aes_block_t  out_data;
  logic        busy;
  logic [31:0] perf_blocks;
  logic [31:0] perf_stalls;

  int errors = 0;
  int checks = 0;
  int n_out  = 0;

  aes_block_t ct_mem [64];
  int         wr_idx = 0;
  int         rd_idx = 0;
  aes_block_t exp_q [$];

  // Datapath model: slot valid, data and number of completed head visits.
  logic       sv [3];
  aes_block_t sd [3];
  logic [3:0] sc [3];

  always #5 clk = ~clk;

  assign fifo_empty = (wr_idx == rd_idx);
  assign pipe_done  = force_done | (sc[2] == LAST_VISIT);
  assign pipe_data  = sd[2] ^ KEY_MASK;

  aes_dec_scheduler #(
    .OUT_DEPTH (OUT_DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .key_ready   (key_ready),
    .fifo_empty  (fifo_empty),
    .read_fifo   (read_fifo),
    .pipe_stall  (pipe_stall),
    .pipe_done   (pipe_done),
    .pipe_data   (pipe_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .busy        (busy),
    .perf_blocks (perf_blocks),
    .perf_stalls (perf_stalls)
  );

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Ring model; an empty slot keeps counting so stale dones appear like on silicon.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        sv[i] <= 1'b0;
        sd[i] <= '0;
        sc[i] <= '0;
      end
      exp_q.delete();
    end else if (!pipe_stall) begin
      for (int i = 1; i < 3; i++) begin
        sv[i] <= sv[i-1];
        sd[i] <= sd[i-1];
        sc[i] <= sc[i-1];
      end
      if (read_fifo) begin
        sv[0] <= 1'b1;
        sd[0] <= ct_mem[rd_idx];
        sc[0] <= 4'd0;
        exp_q.push_back(ct_mem[rd_idx] ^ KEY_MASK);
        rd_idx <= rd_idx + 1;
      end else begin
        sv[0] <= sv[2] && (sc[2] != LAST_VISIT);
        sd[0] <= sd[2];
        sc[0] <= sc[2] + 4'd1;
      end
    end
  end

  // Output side of the scoreboard.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check_eq("spurious_out", 128'(out_valid), 128'(0));
      end else begin
        check_eq("out_data", out_data, exp_q.pop_front());
        n_out++;
      end
    end
  end

  task automatic drive();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic push_ct();
    ct_mem[wr_idx] = {$urandom, $urandom, $urandom, $urandom};
    wr_idx++;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [69:0] rd_mask;
    logic [69:0] exp_rd;
    logic        any_rd;
    aes_block_t  b0;
    int          n0;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    sample();
    check_eq("rst_read_fifo", 128'(read_fifo), 128'(0));
    check_eq("rst_pipe_stall", 128'(pipe_stall), 128'(0));
    check_eq("rst_out_valid", 128'(out_valid), 128'(0));
    check_eq("rst_out_data", out_data, 128'(0));
    check_eq("rst_busy", 128'(busy), 128'(0));
    check_eq("rst_perf_blocks", 128'(perf_blocks), 128'(0));
    check_eq("rst_perf_stalls", 128'(perf_stalls), 128'(0));

    // Single block: pop, 30-cycle round trip, then one more cycle to the output.
    drive();
    key_ready = 1'b1;
    out_ready = 1'b1;
    repeat (4) drive();
    push_ct();
    sample();
    check_eq("single_rd", 128'(read_fifo), 128'(1));
    repeat (AES_PIPE_LATENCY - 1) sample();
    sample();
    check_eq("single_done", 128'(pipe_done), 128'(1));
    check_eq("single_ov_early", 128'(out_valid), 128'(0));
    sample();
    check_eq("single_ov", 128'(out_valid), 128'(1));
    sample();
    check_eq("single_busy", 128'(busy), 128'(0));

    // Full ring: three pops, then each retire frees a slot for the next pop.
    drive();
    n0 = n_out;
    for (int i = 0; i < 6; i++) push_ct();
    rd_mask = '0;
    for (int k = 0; k < 70; k++) begin
      sample();
      rd_mask[k] = read_fifo;
    end
    exp_rd = '0;
    exp_rd[0]  = 1'b1;
    exp_rd[1]  = 1'b1;
    exp_rd[2]  = 1'b1;
    exp_rd[30] = 1'b1;
    exp_rd[31] = 1'b1;
    exp_rd[32] = 1'b1;
    check_eq("ring_rd_pattern", 128'(rd_mask), 128'(exp_rd));
    check_eq("ring_outs", 128'(n_out - n0), 128'(6));
    check_eq("ring_busy", 128'(busy), 128'(0));

    // Back-pressure: two blocks fill the output FIFO, the third stalls the ring.
    drive();
    out_ready = 1'b0;
    n0 = n_out;
    b0 = ct_mem[wr_idx] ;
    for (int i = 0; i < 3; i++) push_ct();
    b0 = ct_mem[wr_idx-3] ^ KEY_MASK;
    for (int k = 0; k < 32; k++) sample();
    check_eq("bp_no_stall_early", 128'(pipe_stall), 128'(0));
    sample();
    check_eq("bp_stall", 128'(pipe_stall), 128'(1));
    repeat (4) sample();
    check_eq("bp_stall_hold", 128'(pipe_stall), 128'(1));
    check_eq("bp_out_stable", out_data, b0);
    drive();
    out_ready = 1'b1;
    sample();
    check_eq("bp_release", 128'(pipe_stall), 128'(0));
    drive();
    out_ready = 1'b0;
    sample();
    check_eq("bp_after", 128'(pipe_stall), 128'(0));
    check_eq("bp_ov_held", 128'(out_valid), 128'(1));
`ifdef AES_SCHED_PERF_EN
    check_eq("bp_perf_stalls", 128'(perf_stalls), 128'(5));
    check_eq("bp_perf_blocks", 128'(perf_blocks), 128'(10));
`else
    check_eq("bp_perf_stalls", 128'(perf_stalls), 128'(0));
    check_eq("bp_perf_blocks", 128'(perf_blocks), 128'(0));
`endif
    drive();
    out_ready = 1'b1;
    repeat (4) sample();
    check_eq("bp_outs", 128'(n_out - n0), 128'(3));
    check_eq("bp_drained", 128'(busy), 128'(0));

    // Key gating: no injection while keys are not ready.
    drive();
    key_ready = 1'b0;
    push_ct();
    push_ct();
    any_rd = 1'b0;
    repeat (10) begin
      sample();
      any_rd |= read_fifo;
    end
    check_eq("key_gated", 128'(any_rd), 128'(0));
    drive();
    key_ready = 1'b1;
    sample();
    check_eq("key_first_pop", 128'(read_fifo), 128'(1));
    repeat (40) sample();
    check_eq("key_busy", 128'(busy), 128'(0));

    // Stale done on an empty ring must not write or stall.
    drive();
    out_ready  = 1'b0;
    force_done = 1'b1;
    sample();
    check_eq("stale_stall", 128'(pipe_stall), 128'(0));
    repeat (2) sample();
    drive();
    force_done = 1'b0;
    sample();
    check_eq("stale_no_write", 128'(out_valid), 128'(0));
    check_eq("stale_busy", 128'(busy), 128'(0));

    // Reset with two blocks in flight.
    drive();
    out_ready = 1'b1;
    push_ct();
    push_ct();
    repeat (15) drive();
    rst = 1'b1;
    drive();
    rst = 1'b0;
    sample();
    check_eq("mrst_out_valid", 128'(out_valid), 128'(0));
    check_eq("mrst_busy", 128'(busy), 128'(0));
    check_eq("mrst_stall", 128'(pipe_stall), 128'(0));
    check_eq("mrst_perf_blocks", 128'(perf_blocks), 128'(0));
    check_eq("mrst_perf_stalls", 128'(perf_stalls), 128'(0));
    repeat (40) sample();
    check_eq("mrst_quiet", 128'(busy), 128'(0));
    check_eq("sb_empty", 128'(exp_q.size()), 128'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/aes_dec_scheduler.md
# aes_dec_scheduler

Slot scheduler and flow controller for the 3-stage recirculating AES decryption pipeline. It tracks which of the three pipeline slots hold live blocks. It pops ciphertext from the input FIFO into free slots, captures finished plaintext into a small output FIFO, and stalls the ring when finished data has nowhere to go. It sits between the ciphertext FIFO, the decryption datapath (`read_fifo`, `is_full`, `data_done`, `data_output`) and the downstream consumer.

## Interface
- `OUT_DEPTH`, 2: output FIFO depth in 128-bit entries; power of two, ≥2.
- `clk`  in  1  system clock.
- `rst`  in  1  reset; synchronous, active-high. The top level drives the datapath's `n_rst` from `~rst`.
- `key_ready`  in  1  round keys are valid; no injection while low.
- `fifo_empty`  in  1  ciphertext FIFO empty.
- `read_fifo`  out  1  pop the ciphertext FIFO and select it into the ring this cycle (to the datapath `read_fifo`).
- `pipe_stall`  out  1  freeze the ring (to the datapath `is_full`).
- `pipe_done`  in  1  datapath `data_done`: the head slot holds a round-10 block.
- `pipe_data`  in  128  datapath `data_output`.
- `out_valid`  out  1  plaintext available.
- `out_ready`  in  1  consumer accepts `out_data` when `out_valid` is also high.
- `out_data`  out  128  plaintext, head of the output FIFO.
- `busy`  out  1  any slot is occupied or the output FIFO is non-empty.
- `perf_blocks`  out  32  completed-block counter (see Configuration).
- `perf_stalls`  out  32  stall-cycle counter (see Configuration).

## Operation
- The occupancy ring `occ[2:0]` mirrors the pipeline. `occ[2]` is the head, aligned with datapath stage C and `pipe_done`.
- When `pipe_stall=0`, the ring rotates every cycle: `occ <= {occ[1:0], ins}`.
- `head_done = occ[2] & pipe_done`. `pipe_done` is ignored when `occ[2]=0`, because a stale state of 10 in an empty slot is garbage.
- `head_free = ~occ[2] | head_done`.
- `ofifo_full`: the output FIFO holds `OUT_DEPTH` entries and no pop happens this cycle. A same-cycle pop frees space.
- `pipe_stall = head_done & ofifo_full`.
- `ins = read_fifo = head_free & ~fifo_empty & key_ready & ~pipe_stall`.
- Output FIFO write = `head_done & ~pipe_stall`, with data `pipe_data`.
- Output FIFO pop = `out_valid & out_ready`.
- Same cycle retire and inject: both happen. The finished block is written to the output FIFO and a new block enters the freed slot.
- Output FIFO full while the head is not done: no stall. The ring keeps rotating and rounds continue.
- `key_ready` falling with blocks in flight: in-flight blocks finish normally; only injection is blocked.
- Reset mid-operation: `occ`, the output FIFO and the counters are cleared, and in-flight blocks are discarded. The datapath is reset in the same cycle.

## Timing
- Reset values: `read_fifo=0`, `pipe_stall=0`, `out_valid=0`, `out_data=0`, `busy=0`, `perf_*=0`.
- `read_fifo` and `pipe_stall` are combinational from the registered state plus `fifo_empty`, `key_ready`, `pipe_done` and `out_ready`.
- Latency: `read_fifo` in cycle T leads to `pipe_done` in T+30 (10 rounds × 3 stages), then `out_valid` in T+31, provided there are no stalls. Each stall cycle adds 1.
- Throughput: at most 3 blocks every 30 cycles.
- `out_data` is stable while `out_valid=1` and `out_ready=0`.

## Configuration
- `AES_SCHED_PERF_EN` defined:
  - `perf_blocks` increments on every output FIFO write.
  - `perf_stalls` increments on every cycle with `pipe_stall=1`.
  - Both counters wrap at 2^32 and clear on `rst`.
- `AES_SCHED_PERF_EN` undefined: both ports are tied to 0 and no counter flops are built.

## Structure
- Package `aes_sched_pkg` holds:
  - `AES_NUM_SLOTS = 3`
  - `AES_LAST_ROUND = 5'd10`
  - `AES_PIPE_LATENCY = 30`
  - `typedef logic [127:0] aes_block_t`
- Sub-module `aes_out_fifo`: `OUT_DEPTH`×128 synchronous FIFO with ports `wr_en`, `wr_data`, `rd_en`, `rd_data`, `full`, `empty`, and show-ahead read.
- The scheduler itself holds the occupancy ring, the issue/stall logic and the perf counters.

## Test plan
- Single block:
  - Stimulus: `key_ready=1`, one FIFO entry, `out_ready=1`; pulse `read_fifo` at cycle 5.
  - Required: `pipe_done` at cycle 35, `out_valid` with matching data at cycle 36; `busy` low again at cycle 37.
- Full ring:
  - Stimulus: 6 entries queued, `out_ready=1`.
  - Required: `read_fifo` in cycles 0, 1, 2; next pops in cycles 30, 31, 32, each coincident with a retire. 6 outputs in order.
- Back-pressure:
  - Stimulus: `out_ready=0`, `OUT_DEPTH=2`, 3 blocks.
  - Required: the third `head_done` raises `pipe_stall` and holds it. Raising `out_ready` for one cycle drops the stall in that same cycle. No data is lost or reordered.
- Key gating:
  - Stimulus: `key_ready=0` with a non-empty FIFO for 10 cycles, then 1.
  - Required: no `read_fifo` while low; the first pop occurs in the cycle `key_ready` rises.
- Stale done:
  - Stimulus: force `pipe_done=1` while `occ=3'b000`.
  - Required: no output FIFO write and no stall.
- Reset mid-flight:
  - Stimulus: assert `rst` at cycle 15 with 2 blocks in flight.
  - Required: next cycle `occ=0`, `out_valid=0`, `busy=0`. With `AES_SCHED_PERF_EN` defined, `perf_*` also read 0.
